decode_stage: RTL and testbench

//  Registered, parametrised instruction-decode pipeline stage. Sits between fetch and execute.

---
 rtl/risc_pkg.sv | 42 ++++
 rtl/reg_scoreboard.sv | 39 +++
 rtl/decode_stage.sv | 244 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared ISA constants for the decode pipeline: opcode codes, instruction
// class codes and the decode-stage FSM state type.
package risc_pkg;

    localparam logic [4:0] OP_AND = 5'd0;
    localparam logic [4:0] OP_EOR = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_RSB = 5'd3;
    localparam logic [4:0] OP_ADD = 5'd4;
    localparam logic [4:0] OP_ADC = 5'd5;
    localparam logic [4:0] OP_SBC = 5'd6;
    localparam logic [4:0] OP_TST = 5'd8;
    localparam logic [4:0] OP_TEQ = 5'd9;
    localparam logic [4:0] OP_CMP = 5'd10;
    localparam logic [4:0] OP_CMN = 5'd11;
    localparam logic [4:0] OP_ORR = 5'd12;
    localparam logic [4:0] OP_MOV = 5'd13;
    localparam logic [4:0] OP_BIC = 5'd14;
    localparam logic [4:0] OP_MVN = 5'd15;
    localparam logic [4:0] OP_LDR = 5'd16;
    localparam logic [4:0] OP_STR = 5'd17;
    localparam logic [4:0] OP_B   = 5'd18;
    localparam logic [4:0] OP_BL  = 5'd19;
    localparam logic [4:0] OP_BEQ = 5'd20;
    localparam logic [4:0] OP_BNE = 5'd21;
    localparam logic [4:0] OP_ILL = 5'h1F;

    // DP opcode field value with no defined operation
    localparam logic [3:0] DP_UNDEF = 4'b0111;

    localparam logic [2:0] CLS_DP_REG = 3'b000;
    localparam logic [2:0] CLS_DP_IMM = 3'b001;
    localparam logic [2:0] CLS_LDST   = 3'b010;
    localparam logic [2:0] CLS_BRANCH = 3'b101;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_AL = 4'hE;

    typedef enum logic {ST_RUN, ST_STALL} stage_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared on write-back, with three busy queries that see same-cycle write-back.
module reg_scoreboard #(
    parameter int unsigned NUM_REGS = 16,
    localparam int unsigned REG_AW  = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_en,
    input  logic [REG_AW-1:0]      set_idx,
    input  logic                   clr_en,
    input  logic [REG_AW-1:0]      clr_idx,
    input  logic [2:0][REG_AW-1:0] query_idx,
    output logic [2:0]             query_busy
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;

    // Clear first so a same-cycle set of the same register wins.
    always_comb begin
        pending_nxt = pending;
        if (clr_en) pending_nxt[clr_idx] = 1'b0;
        if (set_en) pending_nxt[set_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

    always_comb begin
        query_busy = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            query_busy[k] = pending[query_idx[k]] && !(clr_en && clr_idx == query_idx[k]);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with valid/ready handshakes, scoreboard
// hazard stalls, flush, illegal-instruction flagging and a stall counter.
module decode_stage
    import risc_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned IMM_W    = 12,
    parameter int unsigned LINK_REG = 14,
    parameter int unsigned STALL_CW = 16,
    localparam int unsigned REG_AW  = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_W-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_W-1:0]     out_pc,
    output logic [4:0]          out_opcode,
    output logic [3:0]          out_cond,
    output logic [REG_AW-1:0]   out_rd,
    output logic [REG_AW-1:0]   out_rs1,
    output logic [REG_AW-1:0]   out_rs2,
    output logic [IMM_W-1:0]    out_imm,
    output logic [23:0]         out_boff,
    output logic [4:0]          out_shamt,
    output logic [1:0]          out_shtype,
    output logic                out_imm_f,
    output logic                out_reg_we,
    output logic                out_mem_re,
    output logic                out_mem_we,
    output logic                out_byte,
    output logic                out_br,
    output logic                out_link,
    output logic                out_flags_we,
    output logic                out_illegal,
    input  logic                wb_valid,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic                flush,
    output logic [STALL_CW-1:0] stall_cycles
);

    logic [4:0]        d_opcode;
    logic [REG_AW-1:0] d_rd, d_rs1, d_rs2;
    logic [IMM_W-1:0]  d_imm;
    logic [23:0]       d_boff;
    logic [4:0]        d_shamt;
    logic [1:0]        d_shtype;
    logic              d_imm_f, d_reg_we, d_mem_re, d_mem_we, d_byte;
    logic              d_br, d_link, d_flags_we, d_illegal;
    logic              use_rs1, use_rs2;

    always_comb begin
        d_opcode   = OP_ILL;
        d_rd       = '0;
        d_rs1      = '0;
        d_rs2      = '0;
        d_imm      = '0;
        d_boff     = '0;
        d_shamt    = '0;
        d_shtype   = '0;
        d_imm_f    = 1'b0;
        d_reg_we   = 1'b0;
        d_mem_re   = 1'b0;
        d_mem_we   = 1'b0;
        d_byte     = 1'b0;
        d_br       = 1'b0;
        d_link     = 1'b0;
        d_flags_we = 1'b0;
        d_illegal  = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        case (in_instr[27:25])
            CLS_DP_REG, CLS_DP_IMM: begin
                if (in_instr[24:21] == DP_UNDEF) begin
                    d_illegal = 1'b1;
                end else begin
                    d_opcode = {1'b0, in_instr[24:21]};
                    d_rd     = REG_AW'(in_instr[15:12]);
                    d_rs1    = REG_AW'(in_instr[19:16]);
                    use_rs1  = (d_opcode != OP_MOV) && (d_opcode != OP_MVN);
                    if (d_opcode inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN}) begin
                        d_flags_we = 1'b1;
                    end else begin
                        d_reg_we   = 1'b1;
                        d_flags_we = in_instr[20];
                    end
                    if (in_instr[25]) begin
                        d_imm   = IMM_W'(in_instr[11:0]);
                        d_imm_f = 1'b1;
                    end else begin
                        d_rs2    = REG_AW'(in_instr[3:0]);
                        d_shamt  = in_instr[11:7];
                        d_shtype = in_instr[6:5];
                        use_rs2  = 1'b1;
                    end
                end
            end
            CLS_LDST: begin
                d_opcode = in_instr[20] ? OP_LDR : OP_STR;
                d_rd     = REG_AW'(in_instr[15:12]);
                d_rs1    = REG_AW'(in_instr[19:16]);
                d_imm    = IMM_W'(in_instr[11:0]);
                d_imm_f  = 1'b1;
                d_byte   = in_instr[22];
                d_reg_we = in_instr[20];
                d_mem_re = in_instr[20];
                d_mem_we = !in_instr[20];
                use_rs1  = 1'b1;
                // a store reads its data register through the rs2 port
                if (!in_instr[20]) begin
                    d_rs2   = REG_AW'(in_instr[15:12]);
                    use_rs2 = 1'b1;
                end
            end
            CLS_BRANCH: begin
                d_br   = 1'b1;
                d_boff = in_instr[23:0];
                if (in_instr[24]) begin
                    d_opcode = OP_BL;
                    d_link   = 1'b1;
                    d_reg_we = 1'b1;
                    d_rd     = REG_AW'(LINK_REG);
                end else if (in_instr[31:28] == COND_EQ) begin
                    d_opcode = OP_BEQ;
                end else if (in_instr[31:28] == COND_NE) begin
                    d_opcode = OP_BNE;
                end else begin
                    d_opcode = OP_B;
                end
            end
            default: d_illegal = 1'b1;
        endcase
    end

    logic [2:0][REG_AW-1:0] q_idx;
    logic [2:0]             q_pend, q_busy, q_use;
    logic                   hazard, accept, issue;

    assign q_idx = {d_rd, d_rs2, d_rs1};
    assign q_use = {d_reg_we, use_rs2, use_rs1};

    // A staged writer has not yet reached the scoreboard, so it is checked here.
    always_comb begin
        q_busy = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            q_busy[k] = q_pend[k] || (out_valid && out_reg_we && out_rd == q_idx[k]);
        end
    end

    assign hazard   = in_valid && |(q_use & q_busy);
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign issue    = out_valid && out_ready;

    reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (issue && out_reg_we),
        .set_idx    (out_rd),
        .clr_en     (wb_valid),
        .clr_idx    (wb_rd),
        .query_idx  (q_idx),
        .query_busy (q_pend)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_opcode   <= OP_ILL;
            out_cond     <= COND_AL;
            out_rd       <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_imm      <= '0;
            out_boff     <= '0;
            out_shamt    <= '0;
            out_shtype   <= '0;
            out_imm_f    <= 1'b0;
            out_reg_we   <= 1'b0;
            out_mem_re   <= 1'b0;
            out_mem_we   <= 1'b0;
            out_byte     <= 1'b0;
            out_br       <= 1'b0;
            out_link     <= 1'b0;
            out_flags_we <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_opcode   <= d_opcode;
            out_cond     <= in_instr[31:28];
            out_rd       <= d_rd;
            out_rs1      <= d_rs1;
            out_rs2      <= d_rs2;
            out_imm      <= d_imm;
            out_boff     <= d_boff;
            out_shamt    <= d_shamt;
            out_shtype   <= d_shtype;
            out_imm_f    <= d_imm_f;
            out_reg_we   <= d_reg_we;
            out_mem_re   <= d_mem_re;
            out_mem_we   <= d_mem_we;
            out_byte     <= d_byte;
            out_br       <= d_br;
            out_link     <= d_link;
            out_flags_we <= d_flags_we;
            out_illegal  <= d_illegal;
        end else if (issue) begin
            out_valid <= 1'b0;
        end
    end

    stage_state_e state, state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (hazard)  state_nxt = ST_STALL;
            ST_STALL: if (!hazard) state_nxt = ST_RUN;
            default:               state_nxt = ST_RUN;
        endcase
        if (flush) state_nxt = ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_STALL && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + STALL_CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed instruction scenarios followed by random
// traffic, all compared against a transaction-level model of the stage.
module tb_decode_stage;
    import risc_pkg::*;

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready, wb_valid, flush;
    logic [31:0] in_instr, in_pc, out_pc;
    logic [4:0]  out_opcode, out_shamt;
    logic [3:0]  out_cond, out_rd, out_rs1, out_rs2, wb_rd;
    logic [11:0] out_imm;
    logic [23:0] out_boff;
    logic [1:0]  out_shtype;
    logic        out_imm_f, out_reg_we, out_mem_re, out_mem_we, out_byte;
    logic        out_br, out_link, out_flags_we, out_illegal;
    logic [15:0] stall_cycles;

    decode_stage #(.NUM_REGS(16), .PC_W(32), .IMM_W(12), .LINK_REG(14), .STALL_CW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_cond(out_cond), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_boff(out_boff),
        .out_shamt(out_shamt), .out_shtype(out_shtype), .out_imm_f(out_imm_f),
        .out_reg_we(out_reg_we), .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
        .out_byte(out_byte), .out_br(out_br), .out_link(out_link),
        .out_flags_we(out_flags_we), .out_illegal(out_illegal), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .flush(flush), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  cond;
        logic [3:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [23:0] boff;
        logic [4:0]  shamt;
        logic [1:0]  sht;
        logic        imm_f, reg_we, mem_re, mem_we, byt, br, link, flags_we, illegal;
        logic        u1, u2;
    } dec_t;

    // Reference decode, written directly from the instruction-set rules.
    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d = '0;
        d.cond = i[31:28];
        d.op   = 5'h1F;
        case (i[27:25])
            3'b000, 3'b001: begin
                if (i[24:21] == 4'b0111) d.illegal = 1'b1;
                else begin
                    d.op  = {1'b0, i[24:21]};
                    d.rd  = i[15:12];
                    d.rs1 = i[19:16];
                    d.u1  = !(i[24:21] == 4'd13 || i[24:21] == 4'd15);
                    if (i[24:21] >= 4'd8 && i[24:21] <= 4'd11) d.flags_we = 1'b1;
                    else begin d.reg_we = 1'b1; d.flags_we = i[20]; end
                    if (i[25]) begin d.imm = i[11:0]; d.imm_f = 1'b1; end
                    else begin d.rs2 = i[3:0]; d.shamt = i[11:7]; d.sht = i[6:5]; d.u2 = 1'b1; end
                end
            end
            3'b010: begin
                d.op = i[20] ? OP_LDR : OP_STR;
                d.rd = i[15:12]; d.rs1 = i[19:16]; d.imm = i[11:0]; d.imm_f = 1'b1;
                d.u1 = 1'b1; d.byt = i[22];
                if (i[20]) begin d.reg_we = 1'b1; d.mem_re = 1'b1; end
                else begin d.mem_we = 1'b1; d.rs2 = i[15:12]; d.u2 = 1'b1; end
            end
            3'b101: begin
                d.br = 1'b1; d.boff = i[23:0];
                if (i[24]) begin d.op = OP_BL; d.link = 1'b1; d.reg_we = 1'b1; d.rd = 4'd14; end
                else if (i[31:28] == 4'h0) d.op = OP_BEQ;
                else if (i[31:28] == 4'h1) d.op = OP_BNE;
                else d.op = OP_B;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    // Model state: staged bundle, pending-write set, stall flag and counter.
    logic        m_valid;
    logic [31:0] m_pc;
    dec_t        m_d;
    bit [15:0]   m_pend;
    bit          m_stall;
    int unsigned m_cnt;

    function automatic logic [104:0] pack_exp();
        return {m_pc, m_d.op, m_d.cond, m_d.rd, m_d.rs1, m_d.rs2, m_d.imm, m_d.boff,
                m_d.shamt, m_d.sht, m_d.imm_f, m_d.reg_we, m_d.mem_re, m_d.mem_we,
                m_d.byt, m_d.br, m_d.link, m_d.flags_we, m_d.illegal};
    endfunction

    logic [104:0] dut_vec;
    assign dut_vec = {out_pc, out_opcode, out_cond, out_rd, out_rs1, out_rs2, out_imm, out_boff,
                      out_shamt, out_shtype, out_imm_f, out_reg_we, out_mem_re, out_mem_we,
                      out_byte, out_br, out_link, out_flags_we, out_illegal};

    task automatic model_reset();
        m_valid = 1'b0; m_pc = '0; m_d = '0; m_d.op = 5'h1F; m_d.cond = 4'hE;
        m_pend = '0; m_stall = 1'b0; m_cnt = 0;
    endtask

    function automatic bit busy(input logic [3:0] r);
        return (m_pend[r] && !(wb_valid && wb_rd == r)) || (m_valid && m_d.reg_we && m_d.rd == r);
    endfunction

    // One clock: compare at the falling edge, advance the model, return 1ns after the rise.
    task automatic tick();
        dec_t d;
        bit hz, rdy, iss;
        @(negedge clk);
        d   = ref_decode(in_instr);
        hz  = in_valid && ((d.u1 && busy(d.rs1)) || (d.u2 && busy(d.rs2)) || (d.reg_we && busy(d.rd)));
        rdy = !flush && !hz && (!m_valid || out_ready);
        check("in_ready", 128'(in_ready), 128'(rdy));
        check("out_valid", 128'(out_valid), 128'(m_valid));
        check("bundle", 128'(dut_vec), 128'(pack_exp()));
        check("stall_cycles", 128'(stall_cycles), 128'(m_cnt));
        if (rst) model_reset();
        else begin
            iss = m_valid && out_ready;
            if (wb_valid) m_pend[wb_rd] = 1'b0;
            if (iss && m_d.reg_we) m_pend[m_d.rd] = 1'b1;
            if (m_stall && m_cnt < 65535) m_cnt++;
            m_stall = hz && !flush;
            if (flush) m_valid = 1'b0;
            else if (in_valid && rdy) begin m_valid = 1'b1; m_d = d; m_pc = in_pc; end
            else if (iss) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic ordy);
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy;
    endtask

    function automatic logic [3:0] pick_reg();
        logic [3:0] r = 4'($urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) r = 4'd14;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        int unsigned k = $urandom_range(0, 9);
        w[19:16] = pick_reg(); w[15:12] = pick_reg(); w[3:0] = pick_reg();
        if (k <= 2)      w[27:25] = 3'b000;
        else if (k <= 4) w[27:25] = 3'b001;
        else if (k <= 6) w[27:25] = 3'b010;
        else if (k <= 8) begin
            w[27:25] = 3'b101;
            if ($urandom_range(0, 1) == 1) w[31:28] = 4'($urandom_range(0, 1));
        end
        return w;
    endfunction

    initial begin
        int q[$];
        rst = 1'b1; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        present(1'b0, 32'h0, 32'h0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_opcode", 128'(out_opcode), 128'(5'h1F));
        check("rst_cond", 128'(out_cond), 128'(4'hE));
        check("rst_stall", 128'(stall_cycles), 128'(0));
        rst = 1'b0;

        // ADD r1,r2,r3
        present(1'b1, 32'hE0821003, 32'h100, 1'b1);
        tick();
        check("add_op", 128'(out_opcode), 128'(OP_ADD));
        check("add_rd", 128'(out_rd), 128'(1));
        check("add_rs1", 128'(out_rs1), 128'(2));
        check("add_rs2", 128'(out_rs2), 128'(3));
        check("add_we", 128'(out_reg_we), 128'(1));

        // SUB r4,r1,#5 stalls on r1 until write-back
        present(1'b1, 32'hE2414005, 32'h104, 1'b1);
        tick();
        check("sub_stall_ready", 128'(in_ready), 128'(0));
        tick();
        tick();
        wb_valid = 1'b1; wb_rd = 4'd1;
        tick();
        wb_valid = 1'b0;
        check("sub_stall_cnt", 128'(stall_cycles), 128'(3));
        check("sub_op", 128'(out_opcode), 128'(OP_SUB));
        check("sub_imm", 128'(out_imm), 128'(5));
        check("sub_imm_f", 128'(out_imm_f), 128'(1));

        // LDR r5,[r6,#8], then held for three cycles
        present(1'b1, 32'hE5965008, 32'h108, 1'b1);
        tick();
        check("ldr_op", 128'(out_opcode), 128'(OP_LDR));
        check("ldr_re", 128'(out_mem_re), 128'(1));
        check("ldr_imm", 128'(out_imm), 128'(8));
        present(1'b1, 32'hE0887009, 32'h10C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", 128'(out_valid), 128'(1));
            check("hold_op", 128'(out_opcode), 128'(OP_LDR));
            check("hold_pc", 128'(out_pc), 128'(32'h108));
            check("hold_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        tick();

        // BEQ and BL
        present(1'b1, 32'h0A000010, 32'h110, 1'b1);
        tick();
        check("beq_op", 128'(out_opcode), 128'(OP_BEQ));
        check("beq_br", 128'(out_br), 128'(1));
        check("beq_boff", 128'(out_boff), 128'(24'h10));
        present(1'b1, 32'hEB000004, 32'h114, 1'b1);
        tick();
        check("bl_op", 128'(out_opcode), 128'(OP_BL));
        check("bl_link", 128'(out_link), 128'(1));
        check("bl_rd", 128'(out_rd), 128'(14));
        present(1'b1, 32'hE08E0000, 32'h118, 1'b1);
        tick();
        check("bl_pend", 128'(in_ready), 128'(0));
        wb_valid = 1'b1; wb_rd = 4'd14;
        tick();
        wb_valid = 1'b0;
        check("after_bl_rs1", 128'(out_rs1), 128'(14));

        // Illegal word never marks a register pending
        present(1'b1, 32'hEC000000, 32'h11C, 1'b1);
        tick();
        check("ill_flag", 128'(out_illegal), 128'(1));
        check("ill_op", 128'(out_opcode), 128'(5'h1F));
        check("ill_en", 128'({out_reg_we, out_mem_re, out_mem_we, out_br, out_link, out_flags_we}), 128'(0));
        present(1'b1, 32'hE08A900B, 32'h120, 1'b1);
        wb_valid = 1'b1; wb_rd = 4'd0;
        tick();
        wb_valid = 1'b0;
        present(1'b1, 32'hE080C000, 32'h124, 1'b1);
        #1;
        check("ill_no_pend", 128'(in_ready), 128'(1));
        tick();

        // Flush of a held bundle
        present(1'b1, 32'hE08CD00C, 32'h128, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_ready", 128'(in_ready), 128'(0));
        tick();
        flush = 1'b0;
        check("flush_valid", 128'(out_valid), 128'(0));
        #1;
        check("flush_sb", 128'(in_ready), 128'(1));
        tick();

        // Reset in the middle of a stall
        present(1'b1, 32'hE08DB00D, 32'h12C, 1'b1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 128'(out_valid), 128'(0));
        check("mid_rst_op", 128'(out_opcode), 128'(5'h1F));
        check("mid_rst_cond", 128'(out_cond), 128'(4'hE));
        check("mid_rst_stall", 128'(stall_cycles), 128'(0));
        #1;
        check("post_rst_ready", 128'(in_ready), 128'(1));
        tick();

        // Random traffic
        repeat (3000) begin
            present(1'b0, rand_instr(), $urandom, 1'b0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 2) == 0);
            q.delete();
            for (int r = 0; r < 16; r++) if (m_pend[r]) q.push_back(r);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) wb_rd = 4'(q[$urandom_range(0, q.size() - 1)]);
            else wb_rd = 4'($urandom_range(0, 15));
            flush = ($urandom_range(0, 29) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
